// File: rtl/demux16_collect.sv
// Serial bit collector: fills a 16-bit word by auto pointer or explicit select.
// Define DEMUX16_PARITY_EN to add a trailing even-parity check bit (par_err).
module demux16_collect #(
    parameter int N  = 16,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic          addr_mode,
    input  logic [SW-1:0] S,
    output logic [N-1:0]  W,
    output logic          word_valid,
    input  logic          word_ready,
    output logic [SW:0]   bit_cnt
`ifdef DEMUX16_PARITY_EN
    ,
    output logic          par_err
`endif
);

`ifdef DEMUX16_PARITY_EN
    typedef enum logic [1:0] {IDLE, FILL, PAR, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
`endif

    state_t        state, state_nx;
    logic [N-1:0]  mask;
    logic [N-1:0]  mask_nx;
    logic [SW-1:0] ptr;
    logic [SW-1:0] pos;
    logic          mode;
    logic          accept;

`ifdef DEMUX16_PARITY_EN
    assign din_ready = (state == FILL) || (state == PAR);
`else
    assign din_ready = (state == FILL);
`endif
    assign word_valid = (state == HOLD);
    assign accept     = din_valid && din_ready;
    assign pos        = mode ? S : ptr;
    assign mask_nx    = mask | (N'(1) << pos);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = FILL;
            FILL: begin
                if (accept && (&mask_nx)) begin
`ifdef DEMUX16_PARITY_EN
                    state_nx = PAR;
`else
                    state_nx = HOLD;
`endif
                end
            end
`ifdef DEMUX16_PARITY_EN
            PAR:  if (accept) state_nx = HOLD;
`endif
            HOLD: if (word_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            W       <= '0;
            mask    <= '0;
            ptr     <= '0;
            bit_cnt <= '0;
            mode    <= 1'b0;
`ifdef DEMUX16_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mode    <= addr_mode;
                    mask    <= '0;
                    ptr     <= '0;
                    bit_cnt <= '0;
`ifdef DEMUX16_PARITY_EN
                    par_err <= 1'b0;
`endif
                end
                FILL: begin
                    if (accept) begin
                        W[pos] <= din;
                        mask   <= mask_nx;
                        // Rewrites of a known position do not count.
                        if (!mask[pos]) bit_cnt <= bit_cnt + (SW+1)'(1);
                        if (!mode)      ptr     <= ptr + SW'(1);
                    end
                end
`ifdef DEMUX16_PARITY_EN
                PAR: begin
                    if (accept) par_err <= (^W) ^ din;
                end
`endif
                HOLD: begin
                    // Clear on hand-off so IDLE already reads an empty word.
                    if (word_ready) begin
                        mask    <= '0;
                        ptr     <= '0;
                        bit_cnt <= '0;
`ifdef DEMUX16_PARITY_EN
                        par_err <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_demux16_collect.sv
// Randomized bench for demux16_collect against a position-set reference model.
// Define DEMUX16_PARITY_EN to exercise the parity-check phase.
module tb_demux16_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        din_ready;
    logic        addr_mode;
    logic [3:0]  S;
    logic [15:0] W;
    logic        word_valid;
    logic        word_ready;
    logic [4:0]  bit_cnt;
`ifdef DEMUX16_PARITY_EN
    logic        par_err;
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    demux16_collect dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .addr_mode  (addr_mode),
        .S          (S),
        .W          (W),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_cnt    (bit_cnt)
`ifdef DEMUX16_PARITY_EN
        ,
        .par_err    (par_err)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: phase 0 idle, 1 fill, 2 parity, 3 hold.
    logic [15:0] m_w;
    bit          m_wr[16];
    int          m_ptr;
    bit          m_mode;
    int          m_ph;
    bit          m_par;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int m_count();
        int c = 0;
        foreach (m_wr[i]) c += int'(m_wr[i]);
        return c;
    endfunction

    task automatic m_clear();
        foreach (m_wr[i]) m_wr[i] = 1'b0;
        m_ptr = 0;
        m_par = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs();
        chk("bit_cnt", 32'(bit_cnt), 32'(m_count()));
        chk("word_valid", 32'(word_valid), 32'(m_ph == 3));
        chk("din_ready", 32'(din_ready), 32'(m_ph == 1 || m_ph == 2));
        chk("W", 32'(W), 32'(m_w));
`ifdef DEMUX16_PARITY_EN
        chk("par_err", 32'(par_err), 32'(m_par));
`endif
    endtask

    task automatic send(input bit v, input logic [3:0] s, input bit d);
        int pos;
        din_valid  = v;
        S          = s;
        din        = d;
        word_ready = (m_ph == 3) ? 1'b0 : 1'($urandom);
        addr_mode  = 1'($urandom);
        step();
        if (v) begin
            if (m_ph == 1) begin
                pos = m_mode ? int'(s) : m_ptr;
                m_w[pos]   = d;
                m_wr[pos]  = 1'b1;
                if (!m_mode) m_ptr = (m_ptr + 1) % 16;
                if (m_count() == 16) m_ph = PAR_EN ? 2 : 3;
            end else if (m_ph == 2) begin
                m_par = (^m_w) ^ d;
                m_ph  = 3;
            end
        end
        check_outs();
    endtask

    task automatic begin_word(input bit m);
        addr_mode  = m;
        din_valid  = 1'($urandom);
        din        = 1'($urandom);
        word_ready = 1'($urandom);
        step();
        m_mode = m;
        m_ptr  = 0;
        m_ph   = 1;
        check_outs();
    endtask

    task automatic finish_parity(input bit p);
        if (m_ph == 2) send(1'b1, 4'($urandom), p);
    endtask

    task automatic finish_word(input int bp);
        repeat (bp) send(1'b1, 4'($urandom), 1'b0);
        word_ready = 1'b1;
        din_valid  = 1'($urandom);
        step();
        m_ph = 0;
        m_clear();
        check_outs();
        word_ready = 1'b0;
    endtask

    task automatic fill_auto(input logic [15:0] data, input int gap);
        int n = 0;
        bit v;
        while (m_ph == 1 && n < 200) begin
            if (gap == 0)      v = 1'b1;
            else if (gap == 1) v = (n % 2 == 0);
            else               v = 1'($urandom);
            send(v, 4'($urandom), data[m_ptr]);
            n++;
        end
        if (m_ph == 1) chk("fill_timeout", 32'd0, 32'd1);
    endtask

    task automatic fill_explicit(input logic [15:0] data);
        int n = 0;
        int q[$];
        int s;
        bit d;
        while (m_ph == 1 && n < 1000) begin
            q.delete();
            foreach (m_wr[i]) if (!m_wr[i]) q.push_back(i);
            if ($urandom_range(0, 3) == 0) begin
                s = int'($urandom_range(0, 15));
                d = 1'($urandom);
            end else begin
                s = q[$urandom_range(0, q.size() - 1)];
                d = data[s];
            end
            send(($urandom_range(0, 3) != 0), 4'(s), d);
            n++;
        end
        if (m_ph == 1) chk("fill_timeout", 32'd0, 32'd1);
    endtask

    task automatic async_reset();
        #3;
        rst       = 1'b1;
        din_valid = 1'b0;
        #1;
        m_w  = '0;
        m_ph = 0;
        m_clear();
        check_outs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit          m;
        logic [15:0] d;
        rst        = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b0;
        addr_mode  = 1'b0;
        S          = '0;
        word_ready = 1'b0;
        m_w        = '0;
        m_ph       = 0;
        m_mode     = 1'b0;
        m_clear();
        #12;
        check_outs();
        step();
        rst = 1'b0;

        // Auto mode, continuous valid, then backpressure in HOLD.
        begin_word(1'b0);
        fill_auto(16'h3333, 0);
        finish_parity(1'b0);
        chk("auto_W", 32'(W), 32'h3333);
        chk("auto_cnt", 32'(bit_cnt), 32'd16);
        finish_word(10);

        // Explicit mode with a rewrite of position 5.
        begin_word(1'b1);
        for (int s = 0; s < 15; s++) send(1'b1, 4'(s), 1'(s & 1));
        send(1'b1, 4'd5, 1'b0);
        send(1'b1, 4'd15, 1'b1);
        chk("expl_W", 32'(W), 32'hAA8A);
        finish_parity(1'b1);
        finish_word(0);

        // Valid toggling every cycle.
        begin_word(1'b0);
        fill_auto(16'hF00F, 1);
        chk("gap_W", 32'(W), 32'hF00F);
        finish_parity(1'b0);
        finish_word(1);

        // Asynchronous reset after 7 accepts, then a full word.
        begin_word(1'b0);
        for (int i = 0; i < 7; i++) send(1'b1, 4'($urandom), 1'($urandom));
        async_reset();
        chk("rst_W", 32'(W), 32'd0);
        begin_word(1'b0);
        fill_auto(16'hC35A, 2);
        chk("post_rst_W", 32'(W), 32'hC35A);
        finish_parity(1'b1);
        finish_word(2);

`ifdef DEMUX16_PARITY_EN
        begin_word(1'b0);
        fill_auto(16'h3333, 0);
        finish_parity(1'b0);
        chk("par0", 32'(par_err), 32'd0);
        finish_word(0);
        begin_word(1'b0);
        fill_auto(16'h3333, 0);
        finish_parity(1'b1);
        chk("par1", 32'(par_err), 32'd1);
        finish_word(0);
`endif

        for (int k = 0; k < 20; k++) begin
            m = 1'($urandom);
            d = 16'($urandom);
            begin_word(m);
            if (m) fill_explicit(d);
            else   fill_auto(d, 2);
            finish_parity(1'($urandom));
            finish_word(int'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
